// File: rtl/wam_pkg.sv
// Shared constants and helpers for the whack-a-mole hit judge.
package wam_pkg;

  localparam int N_HOLE_DEF = 4;
  localparam int DB_CYC_DEF = 1000000;
  localparam int DB_CYC_SIM = 4;
  localparam int DB_W       = $clog2(DB_CYC_DEF);
  localparam int HIT_NUM_W  = 3;
  localparam int POP_MAX_W  = 7;

  // Number of set bits in a hole vector of up to POP_MAX_W holes.
  function automatic logic [HIT_NUM_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [HIT_NUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + HIT_NUM_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/wam_hit_if.sv
// Switch/mole inputs and judge outputs of the whack-a-mole hit judge.
interface wam_hit_if
  import wam_pkg::*;
#(
  parameter int N_HOLE = N_HOLE_DEF
) ();

  logic                 en;
  logic [N_HOLE-1:0]    sw;
  logic [N_HOLE-1:0]    mole;
  logic [N_HOLE-1:0]    hit;
  logic                 hit_any;
  logic [HIT_NUM_W-1:0] hit_num;
  logic                 miss;

  modport master (
    output en, sw, mole,
    input  hit, hit_any, hit_num, miss
  );

  modport slave (
    input  en, sw, mole,
    output hit, hit_any, hit_num, miss
  );

endinterface

// File: rtl/wam_dbn.sv
// One hole: 2-flop synchroniser, debounce counter and rising-edge press pulse.
module wam_dbn
  import wam_pkg::*;
#(
  parameter int DB_CYC = DB_CYC_SIM
) (
  input  logic clk,
  input  logic clr_n,
  input  logic sw,
  output logic press
);

  localparam int              CNT_W    = $clog2(DB_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sw_s_q, sw_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_dly_q, stable_dly_d;

  // Debounce: stable only follows sw_s after DB_CYC consecutive mismatching cycles.
  always_comb begin
    sync1_d      = sw;
    sw_s_d       = sync1_q;
    cnt_d        = '0;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    if (sw_s_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sw_s_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; everything clears on reset so a pending debounce is dropped.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sync1_q      <= 1'b0;
      sw_s_q       <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sw_s_q       <= sw_s_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
    end
  end

  // Only the press edge is judged; releases produce nothing.
  assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/wam_hit.sv
// Hit judge: debounced presses are scored against the live mole mask.
module wam_hit
  import wam_pkg::*;
#(
  parameter int N_HOLE = N_HOLE_DEF,
  parameter int DB_CYC = DB_CYC_DEF
) (
  input  logic      clk,
  input  logic      clr_n,
  wam_hit_if.slave  bus
);

  logic [N_HOLE-1:0]    press;
  logic [N_HOLE-1:0]    whacked_q, whacked_d;
  logic [N_HOLE-1:0]    hit_q, hit_d;
  logic                 hit_any_q, hit_any_d;
  logic [HIT_NUM_W-1:0] hit_num_q, hit_num_d;
  logic                 miss_q, miss_d;

  for (genvar i = 0; i < N_HOLE; i++) begin : g_hole
    wam_dbn #(.DB_CYC(DB_CYC)) u_dbn (
      .clk   (clk),
      .clr_n (clr_n),
      .sw    (bus.sw[i]),
      .press (press[i])
    );
  end

  // Judge each press: first press on a showing mole scores, a press on an empty hole misses,
  // further presses on an already-whacked mole are ignored. whacked drops with the mole or en.
  always_comb begin
    hit_d     = '0;
    miss_d    = 1'b0;
    whacked_d = '0;
    if (bus.en) begin
      hit_d     = press & bus.mole & ~whacked_q;
      miss_d    = |(press & ~bus.mole);
      whacked_d = (whacked_q | hit_d) & bus.mole;
    end
    hit_any_d = |hit_d;
    hit_num_d = popcount(POP_MAX_W'(hit_d));
  end

  // Registered judge outputs and the per-hole whacked memory.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      whacked_q <= '0;
      hit_q     <= '0;
      hit_any_q <= 1'b0;
      hit_num_q <= '0;
      miss_q    <= 1'b0;
    end else begin
      whacked_q <= whacked_d;
      hit_q     <= hit_d;
      hit_any_q <= hit_any_d;
      hit_num_q <= hit_num_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_any = hit_any_q;
  assign bus.hit_num = hit_num_q;
  assign bus.miss    = miss_q;

endmodule

// File: tb/tb_wam_hit.sv
// Bench for wam_hit: directed scenarios with literal expectations plus random play,
// every cycle compared against a behavioural model of the judge.
module tb_wam_hit;
  import wam_pkg::*;

  localparam int N  = 4;
  localparam int DB = DB_CYC_SIM;

  logic clk = 1'b0;
  logic clr_n;

  wam_hit_if #(.N_HOLE(N)) bus ();

  wam_hit #(.N_HOLE(N), .DB_CYC(DB)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: raw switch samples (hist[j] = sw seen j+1 edges ago), debounced level,
  // previous debounced level, moles already scored, and expected outputs.
  logic [N-1:0] hist [0:DB];
  logic [N-1:0] m_stable   = '0;
  logic [N-1:0] m_prev     = '0;
  logic [N-1:0] m_whacked  = '0;
  logic [N-1:0] exp_hit    = '0;
  logic         exp_any    = 1'b0;
  logic         exp_miss   = 1'b0;
  logic [2:0]   exp_num    = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] press;
    if (!clr_n) begin
      for (int j = 0; j <= DB; j++) hist[j] = '0;
      m_stable  = '0;
      m_prev    = '0;
      m_whacked = '0;
      exp_hit   = '0;
      exp_miss  = 1'b0;
    end else begin
      press = m_stable & ~m_prev;
      if (bus.en) begin
        exp_hit   = press & bus.mole & ~m_whacked;
        exp_miss  = |(press & ~bus.mole);
        m_whacked = (m_whacked | exp_hit) & bus.mole;
      end else begin
        exp_hit   = '0;
        exp_miss  = 1'b0;
        m_whacked = '0;
      end
      m_prev = m_stable;
      // A hole changes level once DB synchronised samples in a row disagree with it.
      for (int i = 0; i < N; i++) begin
        bit flip;
        flip = 1'b1;
        for (int j = 1; j <= DB; j++) begin
          if (hist[j][i] == m_stable[i]) flip = 1'b0;
        end
        if (flip) m_stable[i] = ~m_stable[i];
      end
      for (int j = DB; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = bus.sw;
    end
    exp_num = 3'($countones(exp_hit));
    exp_any = (exp_hit != '0);
  endtask

  // One clock: model steps at the edge, DUT compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m_hit",     32'(bus.hit),     32'(exp_hit));
    chk("m_hit_any", 32'(bus.hit_any), 32'(exp_any));
    chk("m_hit_num", 32'(bus.hit_num), 32'(exp_num));
    chk("m_miss",    32'(bus.miss),    32'(exp_miss));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int hold [N];

  initial begin
    for (int j = 0; j <= DB; j++) hist[j] = '0;
    clr_n    = 1'b0;
    bus.en   = 1'b1;
    bus.sw   = 4'hF;
    bus.mole = 4'hF;

    // Reset holds every output low even with all switches and moles active.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_hit", 32'(bus.hit), 32'h0);
      chk("rst_any", 32'(bus.hit_any), 32'h0);
      chk("rst_num", 32'(bus.hit_num), 32'h0);
      chk("rst_miss", 32'(bus.miss), 32'h0);
    end
    bus.sw   = '0;
    bus.mole = '0;
    clr_n    = 1'b1;
    idle(8);

    // Single press on a showing mole: one hit at clk 7, then a re-press is ignored.
    bus.mole = 4'b0100;
    tick();
    bus.sw = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t2_hit", 32'(bus.hit), (c == 7) ? 32'h4 : 32'h0);
      chk("t2_any", 32'(bus.hit_any), (c == 7) ? 32'h1 : 32'h0);
      chk("t2_num", 32'(bus.hit_num), (c == 7) ? 32'h1 : 32'h0);
      chk("t2_miss", 32'(bus.miss), 32'h0);
    end
    bus.sw = '0;
    idle(8);
    bus.sw = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("t2_repress_any", 32'(bus.hit_any), 32'h0);
      chk("t2_repress_miss", 32'(bus.miss), 32'h0);
    end
    bus.sw = '0;
    idle(8);

    // Bouncing switch never settles long enough to register.
    bus.mole = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      bus.sw[0] = ((c / 2) % 2) == 0;
      tick();
      chk("t3_any", 32'(bus.hit_any), 32'h0);
      chk("t3_miss", 32'(bus.miss), 32'h0);
    end
    bus.sw = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("t3_tail_any", 32'(bus.hit_any), 32'h0);
      chk("t3_tail_miss", 32'(bus.miss), 32'h0);
    end

    // Press on an empty hole: one miss at clk 7.
    bus.mole = 4'b0000;
    tick();
    bus.sw = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t4_miss", 32'(bus.miss), (c == 7) ? 32'h1 : 32'h0);
      chk("t4_hit", 32'(bus.hit), 32'h0);
    end
    bus.sw = '0;
    idle(8);

    // Two holes hit together.
    bus.mole = 4'b1001;
    tick();
    bus.sw = 4'b1001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5_hit", 32'(bus.hit), (c == 7) ? 32'h9 : 32'h0);
      chk("t5_num", 32'(bus.hit_num), (c == 7) ? 32'h2 : 32'h0);
      chk("t5_any", 32'(bus.hit_any), (c == 7) ? 32'h1 : 32'h0);
    end
    bus.sw   = '0;
    bus.mole = '0;
    idle(8);

    // Hit and miss in the same cycle.
    bus.mole = 4'b1000;
    tick();
    bus.sw = 4'b1001;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5b_hit", 32'(bus.hit), (c == 7) ? 32'h8 : 32'h0);
      chk("t5b_miss", 32'(bus.miss), (c == 7) ? 32'h1 : 32'h0);
      chk("t5b_num", 32'(bus.hit_num), (c == 7) ? 32'h1 : 32'h0);
    end
    bus.sw   = '0;
    bus.mole = '0;
    idle(8);

    // Reset in the middle of a debounce restarts it from release.
    bus.mole = 4'b0100;
    tick();
    bus.sw = 4'b0100;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("t6_hit", 32'(bus.hit), (c == 11) ? 32'h4 : 32'h0);
      chk("t6_miss", 32'(bus.miss), 32'h0);
      clr_n = (c != 3);
    end
    clr_n    = 1'b1;
    bus.sw   = '0;
    bus.mole = '0;
    idle(8);

    // A press landing while disabled is dropped, not deferred.
    bus.mole = 4'b0100;
    bus.en   = 1'b0;
    tick();
    bus.sw = 4'b0100;
    for (int c = 1; c <= 22; c++) begin
      tick();
      chk("t6_en_any", 32'(bus.hit_any), 32'h0);
      chk("t6_en_miss", 32'(bus.miss), 32'h0);
      if (c == 11) bus.en = 1'b1;
    end
    bus.sw = '0;
    idle(8);

    // Random play against the model.
    for (int i = 0; i < N; i++) hold[i] = $urandom_range(12, 1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          bus.sw[i] = ~bus.sw[i];
          hold[i]   = $urandom_range(12, 1);
        end
      end
      if ($urandom_range(9, 0) == 0) bus.mole = 4'($urandom_range(15, 0));
      if ($urandom_range(99, 0) == 0) bus.en = ~bus.en;
      clr_n = ($urandom_range(399, 0) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
